// File: rtl/rvm_axi4_bridge_if.sv
// AXI4 master-side channel bundle used by rvm_axi4_bridge (single beat, no IDs or bursts).
interface rvm_axi4_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARSIZE;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWSIZE;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output ARADDR, ARSIZE, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY,
    output AWADDR, AWSIZE, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY
  );

  modport slave (
    input  ARADDR, ARSIZE, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY,
    input  AWADDR, AWSIZE, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY
  );
endinterface

// File: rtl/rvm_axi4_bridge.sv
// Single-outstanding bridge from the rvm core SRAM-style port to an AXI4 master,
// with a response timeout that latches a sticky bus fault.
module rvm_axi4_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_b_en,
  input  logic                mem_c_en,
  input  logic                mem_w_en,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  output logic                mem_error,
  output logic                bus_fault,
  rvm_axi4_bridge_if.master   m_axi
);
  localparam int               STRB_W   = DATA_W / 8;
  localparam logic [2:0]       AXI_SIZE = 3'($clog2(STRB_W));
  localparam bit               TO_EN    = (TIMEOUT_CYC != 0);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   ben_q, ben_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                fault_q, fault_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy;
  logic                timeout;
  logic                aw_hs;
  logic                w_hs;

  assign busy = (state_q == S_AR) || (state_q == S_R) || (state_q == S_WR) || (state_q == S_B);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ben_d     = ben_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    fault_d   = fault_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = '0;
    timeout   = 1'b0;
    aw_hs     = aw_done_q | m_axi.AWREADY;
    w_hs      = w_done_q | m_axi.WREADY;

    // Cycle count while waiting on the bus; the last allowed cycle fires the timeout.
    if (busy && TO_EN) begin
      cnt_d   = cnt_q + CNT_W'(1);
      timeout = (cnt_q >= TO_LAST);
    end

    case (state_q)
      S_IDLE: begin
        if (mem_c_en) begin
          if (fault_q) begin
            state_d = S_DONE;
            error_d = 1'b1;
            rdata_d = '0;
          end else begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            ben_d   = mem_b_en;
            state_d = mem_w_en ? S_WR : S_AR;
          end
        end
      end
      S_AR: begin
        if (timeout)             state_d = S_DONE;
        else if (m_axi.ARREADY)  state_d = S_R;
      end
      S_R: begin
        // A response landing on the final cycle still wins over the timeout.
        if (m_axi.RVALID) begin
          rdata_d = m_axi.RDATA;
          error_d = |m_axi.RRESP;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_WR: begin
        if (timeout) begin
          state_d = S_DONE;
        end else if (aw_hs && w_hs) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end else begin
          aw_done_d = aw_hs;
          w_done_d  = w_hs;
        end
      end
      S_B: begin
        if (m_axi.BVALID) begin
          error_d = |m_axi.BRESP;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Late responses can no longer be matched to a request, so the fault sticks until reset.
    if (timeout && !(state_q == S_R && m_axi.RVALID) && !(state_q == S_B && m_axi.BVALID)) begin
      error_d   = 1'b1;
      rdata_d   = '0;
      fault_d   = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      ben_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      fault_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ben_q     <= ben_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      fault_q   <= fault_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARSIZE  = AXI_SIZE;
  assign m_axi.ARVALID = (state_q == S_AR);
  assign m_axi.RREADY  = (state_q == S_R);
  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWSIZE  = AXI_SIZE;
  assign m_axi.AWVALID = (state_q == S_WR) && !aw_done_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = ben_q;
  assign m_axi.WVALID  = (state_q == S_WR) && !w_done_q;
  assign m_axi.BREADY  = (state_q == S_B);

  assign mem_stall = ARESETn && (((state_q == S_IDLE) && mem_c_en) || busy);
  assign mem_error = (state_q == S_DONE) && error_q;
  assign mem_rdata = rdata_q;
  assign bus_fault = fault_q;
endmodule

// File: tb/tb_rvm_axi4_bridge.sv
// Directed bench for rvm_axi4_bridge: 32-bit DUT behind a delay-configurable AXI slave,
// plus a 64-bit DUT driven step by step; results checked through scoreboard queues.
module tb_rvm_axi4_bridge;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t wsb[$];

  // 32-bit DUT, short timeout
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_b_en;
  logic        mem_c_en, mem_w_en, mem_stall, mem_error, bus_fault;
  rvm_axi4_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();
  rvm_axi4_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_b_en(mem_b_en),
    .mem_c_en(mem_c_en), .mem_w_en(mem_w_en), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .mem_error(mem_error), .bus_fault(bus_fault),
    .m_axi(axi)
  );

  // 64-bit DUT
  logic [31:0] w_addr;
  logic [63:0] w_wdata, w_rdata;
  logic [7:0]  w_b_en;
  logic        w_c_en, w_we, w_stall, w_error, w_fault;
  rvm_axi4_bridge_if #(.ADDR_W(32), .DATA_W(64)) axi64 ();
  rvm_axi4_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(64)) dut64 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_b_en(w_b_en),
    .mem_c_en(w_c_en), .mem_w_en(w_we), .mem_rdata(w_rdata),
    .mem_stall(w_stall), .mem_error(w_error), .bus_fault(w_fault),
    .m_axi(axi64)
  );

  // Slave delay settings (-1 = never ready) and monitor results for the 32-bit DUT
  int          ar_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = '0, b_resp = '0;
  int          arv_n, awv_n, wv_n, unstable;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;
  logic [2:0]  seen_arsize, seen_awsize;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave for the 32-bit DUT: inputs change on the falling edge only
  initial begin
    int ar_w, aw_w, w_w, b_w;
    bit r_pend, b_pend, aw_got, w_got;
    ar_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = '0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = '0;
        ar_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        axi.RVALID = r_pend;
        axi.RDATA  = r_pend ? r_data : '0;
        axi.RRESP  = r_resp;
        if (axi.RVALID && axi.RREADY) r_pend = 0;
        b_w = b_pend ? b_w + 1 : 0;
        axi.BVALID = b_pend && (b_dly >= 0) && (b_w > b_dly);
        axi.BRESP  = b_resp;
        if (axi.BVALID && axi.BREADY) b_pend = 0;
        ar_w = axi.ARVALID ? ar_w + 1 : 0;
        aw_w = axi.AWVALID ? aw_w + 1 : 0;
        w_w  = axi.WVALID  ? w_w + 1  : 0;
        axi.ARREADY = axi.ARVALID && (ar_dly >= 0) && (ar_w > ar_dly);
        axi.AWREADY = axi.AWVALID && (aw_dly >= 0) && (aw_w > aw_dly);
        axi.WREADY  = axi.WVALID  && (w_dly >= 0)  && (w_w > w_dly);
        if (axi.ARVALID && axi.ARREADY) r_pend = 1;
        if (axi.AWVALID && axi.AWREADY) aw_got = 1;
        if (axi.WVALID && axi.WREADY)   w_got = 1;
        if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
        if (axi.ARVALID) begin
          arv_n++;
          if (arv_n > 1 && axi.ARADDR !== seen_araddr) unstable++;
          seen_araddr = axi.ARADDR; seen_arsize = axi.ARSIZE;
        end
        if (axi.AWVALID) begin
          awv_n++;
          if (awv_n > 1 && axi.AWADDR !== seen_awaddr) unstable++;
          seen_awaddr = axi.AWADDR; seen_awsize = axi.AWSIZE;
        end
        if (axi.WVALID) begin
          wv_n++;
          if (wv_n > 1 && (axi.WDATA !== seen_wdata || axi.WSTRB !== seen_wstrb)) unstable++;
          seen_wdata = axi.WDATA; seen_wstrb = axi.WSTRB;
        end
      end
    end
  end

  // One request on the 32-bit DUT; exp_lat counts falling edges from request to DONE
  task automatic do_txn(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] ben,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    exp_t e;
    int   n;
    e.rdata = {32'h0, exp_rd};
    e.err   = exp_err;
    sb.push_back(e);
    arv_n = 0; awv_n = 0; wv_n = 0; unstable = 0;
    @(negedge ACLK);
    mem_addr = addr; mem_wdata = wdata; mem_b_en = ben; mem_w_en = we; mem_c_en = 1'b1;
    #1 chk({tag, ".stall_req"}, mem_stall, 1);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (mem_stall && n < 50);
    chk({tag, ".latency"}, n, exp_lat);
    e = sb.pop_front();
    chk({tag, ".rdata"}, mem_rdata, e.rdata);
    chk({tag, ".error"}, mem_error, e.err);
    $display("txn %s we=%0d addr=%h rdata=%h err=%0d lat=%0d", tag, we, addr, mem_rdata, mem_error, n);
    mem_c_en = 1'b0;
  endtask

  initial begin
    exp_t e;
    mem_addr = '0; mem_wdata = '0; mem_b_en = '0; mem_c_en = 0; mem_w_en = 0;
    w_addr = '0; w_wdata = '0; w_b_en = '0; w_c_en = 0; w_we = 0;
    axi64.ARREADY = 0; axi64.RVALID = 0; axi64.RDATA = '0; axi64.RRESP = '0;
    axi64.AWREADY = 0; axi64.WREADY = 0; axi64.BVALID = 0; axi64.BRESP = '0;

    repeat (3) @(negedge ACLK);
    chk("rst.valid_ready", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY}, 0);
    chk("rst.stall_err_fault", {mem_stall, mem_error, bus_fault}, 0);
    chk("rst.rdata", mem_rdata, 0);
    chk("rst64.valid_ready", {axi64.ARVALID, axi64.AWVALID, axi64.WVALID, w_stall, w_fault}, 0);
    ARESETn = 1'b1;

    // Minimum-latency read
    r_data = 32'hDEADBEEF;
    do_txn("read", 0, 32'h100, 0, 0, 32'hDEADBEEF, 0, 3);
    chk("read.arvalid_cycles", arv_n, 1);
    chk("read.araddr", seen_araddr, 32'h100);
    chk("read.arsize", seen_arsize, 3'b010);

    // Staggered write: AWREADY after 3 waiting cycles, WREADY at once, SLVERR response
    aw_dly = 3; w_dly = 0; b_resp = 2'b10;
    do_txn("wr_stag", 1, 32'h204, 32'h12345678, 4'b0011, 32'hDEADBEEF, 1, 6);
    chk("wr_stag.awvalid_cycles", awv_n, 4);
    chk("wr_stag.wvalid_cycles", wv_n, 1);
    chk("wr_stag.wstrb", seen_wstrb, 4'h3);
    chk("wr_stag.wdata", seen_wdata, 32'h12345678);
    chk("wr_stag.awaddr", seen_awaddr, 32'h204);
    chk("wr_stag.awsize", seen_awsize, 3'b010);
    chk("wr_stag.stable", unstable, 0);
    @(negedge ACLK);
    chk("wr_stag.error_one_cycle", mem_error, 0);

    // AW and W handshakes in the same cycle
    aw_dly = 1; w_dly = 1; b_resp = 2'b00;
    do_txn("wr_sim", 1, 32'h300, 32'hA5A55A5A, 4'hF, 32'hDEADBEEF, 0, 4);
    chk("wr_sim.awvalid_cycles", awv_n, 2);
    chk("wr_sim.wvalid_cycles", wv_n, 2);

    // Minimum-latency write
    aw_dly = 0; w_dly = 0;
    do_txn("wr_min", 1, 32'h304, 32'h0BADF00D, 4'hC, 32'hDEADBEEF, 0, 3);
    chk("wr_min.valid_cycles", {awv_n[7:0], wv_n[7:0]}, 16'h0101);

    // Reset while waiting in B
    b_dly = -1;
    @(negedge ACLK);
    mem_addr = 32'h400; mem_wdata = 32'h11112222; mem_b_en = 4'hF; mem_w_en = 1; mem_c_en = 1;
    repeat (2) @(negedge ACLK);
    chk("rst_b.bready_before", axi.BREADY, 1);
    #2 ARESETn = 1'b0;
    #1 chk("rst_b.bready", axi.BREADY, 0);
    chk("rst_b.stall", mem_stall, 0);
    chk("rst_b.rdata", mem_rdata, 0);
    $display("txn rst_b reset asserted in B bready=%0d stall=%0d", axi.BREADY, mem_stall);
    repeat (2) @(negedge ACLK);
    mem_c_en = 0; b_dly = 0; ARESETn = 1'b1;
    r_data = 32'hCAFEF00D;
    do_txn("rd_after_rst", 0, 32'h104, 0, 0, 32'hCAFEF00D, 0, 3);

    // 64-bit read then write, stepped by hand
    e.rdata = 64'h0123456789ABCDEF; e.err = 0;
    wsb.push_back(e);
    @(negedge ACLK);
    w_addr = 32'h200; w_we = 0; w_c_en = 1; axi64.ARREADY = 1;
    @(negedge ACLK);
    chk("w64_rd.arvalid", axi64.ARVALID, 1);
    chk("w64_rd.arsize", axi64.ARSIZE, 3'b011);
    axi64.RVALID = 1; axi64.RDATA = 64'h0123456789ABCDEF; axi64.RRESP = 2'b00;
    @(negedge ACLK);
    chk("w64_rd.rready", axi64.RREADY, 1);
    axi64.ARREADY = 0;
    @(negedge ACLK);
    e = wsb.pop_front();
    chk("w64_rd.stall", w_stall, 0);
    chk("w64_rd.rdata", w_rdata, e.rdata);
    chk("w64_rd.error", w_error, e.err);
    $display("txn w64_rd addr=%h rdata=%h err=%0d", w_addr, w_rdata, w_error);
    axi64.RVALID = 0; axi64.RDATA = '0; w_c_en = 0;

    e.rdata = 64'h0123456789ABCDEF; e.err = 0;
    wsb.push_back(e);
    @(negedge ACLK);
    w_addr = 32'h208; w_we = 1; w_wdata = 64'hFEDCBA9876543210; w_b_en = 8'hF0; w_c_en = 1;
    axi64.AWREADY = 1; axi64.WREADY = 1;
    @(negedge ACLK);
    chk("w64_wr.valids", {axi64.AWVALID, axi64.WVALID}, 2'b11);
    chk("w64_wr.awsize", axi64.AWSIZE, 3'b011);
    chk("w64_wr.wstrb", axi64.WSTRB, 8'hF0);
    chk("w64_wr.wdata", axi64.WDATA, 64'hFEDCBA9876543210);
    @(negedge ACLK);
    axi64.AWREADY = 0; axi64.WREADY = 0; axi64.BVALID = 1; axi64.BRESP = 2'b00;
    chk("w64_wr.bready", axi64.BREADY, 1);
    @(negedge ACLK);
    e = wsb.pop_front();
    chk("w64_wr.rdata_kept", w_rdata, e.rdata);
    chk("w64_wr.error", w_error, e.err);
    $display("txn w64_wr addr=%h wstrb=f0 err=%0d", w_addr, w_error);
    axi64.BVALID = 0; w_c_en = 0;

    // Timeout with ARREADY stuck low, then a write refused by the sticky fault
    ar_dly = -1;
    do_txn("timeout", 0, 32'h500, 0, 0, 32'h0, 1, 9);
    chk("timeout.arvalid_cycles", arv_n, 8);
    chk("timeout.bus_fault", bus_fault, 1);
    chk("timeout.valids_done", {axi.ARVALID, axi.RREADY}, 0);
    ar_dly = 0;
    do_txn("fault_wr", 1, 32'h504, 32'h55AA55AA, 4'hF, 32'h0, 1, 2 - 1);
    chk("fault_wr.no_bus", {awv_n[7:0], wv_n[7:0]}, 16'h0000);
    chk("fault_wr.bus_fault", bus_fault, 1);

    // Only reset clears the fault
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1 chk("fault_clr.bus_fault", bus_fault, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    r_data = 32'h13579BDF;
    do_txn("rd_clean", 0, 32'h108, 0, 0, 32'h13579BDF, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rvm_axi4_bridge.md
# rvm_axi4_bridge

Parametrised single-outstanding-transaction bridge between the rvm core SRAM-style memory port and an AXI4 master interface. It latches each core request, runs an explicit AR/R or AW+W/B handshake sequence with payload held stable, and returns registered read data and error status. It is generalised in address and data width and adds a response timeout with a sticky bus-fault mode. It sits between `rvm_core` and the system interconnect.

## Interface
- ADDR_W, 32, address width of mem_addr and AxADDR.
- DATA_W, 32, data width; legal values 32 or 64. STRB_W = DATA_W/8.
- TIMEOUT_CYC, 1024, maximum number of cycles spent waiting in AR/R/WR/B before a timeout; 0 disables the timeout.
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- mem_addr  in  ADDR_W  request address.
- mem_wdata  in  DATA_W  write data.
- mem_b_en  in  STRB_W  byte enables.
- mem_c_en  in  1  request valid.
- mem_w_en  in  1  1 = write, 0 = read.
- mem_rdata  out  DATA_W  read data, valid in DONE.
- mem_stall  out  1  core must hold its request.
- mem_error  out  1  response error, valid in DONE.
- bus_fault  out  1  sticky timeout flag.
- M_AXI_AR{ADDR,SIZE,VALID,READY}, M_AXI_R{DATA,RESP,VALID,READY}: ADDR_W, 3, 1, 1 and DATA_W, 2, 1, 1. Directions are standard for an AXI master.
- M_AXI_AW{ADDR,SIZE,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}: standard master directions.

## Operation
- **States:** IDLE, AR, R, WR, B, DONE.
- **IDLE, mem_c_en=1, bus_fault=0:** latch addr, wdata, b_en and w_en. Go to WR if w_en=1, otherwise go to AR.
- **IDLE, mem_c_en=1, bus_fault=1:** go directly to DONE with error=1 and rdata=0. There is no bus activity.
- **AR:** ARVALID=1. On ARREADY, go to R.
- **R:** RREADY=1. On RVALID, capture RDATA into rdata and set error=(RRESP!=0), then go to DONE.
- **WR:** AWVALID=!aw_done and WVALID=!w_done.
  - aw_done is set on AWREADY and w_done is set on WREADY, independently.
  - When both are done, or both handshakes land in the same cycle, go to B and clear both flags.
- **B:** BREADY=1. On BVALID, set error=(BRESP!=0) and go to DONE. rdata is unchanged.
- **DONE:** lasts one cycle, then go to IDLE. mem_c_en is ignored in DONE because it belongs to the request that just completed.
- **Outputs:**
  - mem_stall = (state==IDLE && mem_c_en) || state∈{AR,R,WR,B}.
  - mem_error = (state==DONE) && error.
  - mem_rdata = rdata register.
- **Payload:** AxADDR, WDATA and WSTRB are driven from the latched registers. They are stable for the whole time VALID is high.
- **Size:** AxSIZE = log2(STRB_W), i.e. 3'b010 for 32-bit and 3'b011 for 64-bit. The address is passed unaligned; alignment is the core's responsibility.
- **Timeout:**
  - The counter clears in IDLE/DONE and increments each cycle in AR/R/WR/B.
  - When the count reaches TIMEOUT_CYC, go to DONE with error=1 and rdata=0, and set bus_fault.
  - All VALID/READY outputs drop in DONE.
  - bus_fault clears only on reset, because late responses can no longer be associated with a request.

## Timing
- **Reset values:** all VALID/READY outputs 0, mem_stall 0, mem_error 0, mem_rdata 0, bus_fault 0, state IDLE, counter 0.
- **Reset mid-transaction:** outputs return to their reset values immediately (asynchronous). No transaction is retried.
- **Minimum read latency** with ARREADY=1 and RVALID one cycle after AR:
  - request at T;
  - AR at T+1;
  - R at T+2;
  - DONE at T+3.
  - mem_stall is high for T..T+2 and low at T+3.
- **Minimum write latency** with AWREADY=WREADY=1 and BVALID one cycle after:
  - WR at T+1;
  - B at T+2;
  - DONE at T+3.
- **Back-to-back requests:** a request held high across DONE is accepted again in the next IDLE. The throughput limit is therefore one transaction per 4 cycles.
- **VALID behaviour:** VALID never deasserts before its READY, except on timeout or reset.

## Test plan
- **Read:** addr 0x100, ARREADY=1, RVALID 1 cycle later with RDATA=0xDEADBEEF, RRESP=0 -> ARVALID at T+1, mem_stall high T..T+2, mem_rdata=0xDEADBEEF and mem_error=0 at T+3.
- **Write, staggered handshakes:** wdata 0x12345678, b_en 4'b0011; AWREADY delayed 3 cycles, WREADY immediate -> WVALID for 1 cycle, AWVALID for 4 cycles, WSTRB=0x3; BVALID with BRESP=2'b10 -> mem_error=1 for one cycle.
- **Simultaneous AW/W:** AWREADY and WREADY asserted in the same cycle -> the next cycle is B, and neither VALID is reasserted.
- **Timeout:** TIMEOUT_CYC=8, ARREADY stuck at 0 -> ARVALID high for 8 cycles, then DONE with mem_error=1, bus_fault=1. A following write completes in 2 cycles with error=1 and no AWVALID.
- **Wide mode:** DATA_W=64, read and write -> ARSIZE=AWSIZE=3'b011, WSTRB=8'hF0 passed through, 64-bit rdata returned.
- **Reset mid-operation:** ARESETn pulsed low while in B -> BREADY=0 and mem_stall=0 immediately. After release, a new read completes normally.
